dmem_pipe: RTL and testbench

DMEM_PIPE -- requirements
Module: dmem_pipe

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/load_extend.sv | 29 ++
 rtl/dmem_pipe.sv | 136 +++++++++++++
 tb/tb_dmem_pipe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory pipe: operation codes and FSM states.
package dmem_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LH  = 4'd1,
    LW  = 4'd2,
    LBU = 4'd3,
    LHU = 4'd4,
    SB  = 4'd5,
    SH  = 4'd6,
    SW  = 4'd7
  } addr_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  function automatic logic is_store(logic [3:0] m);
    return (m == SB) || (m == SH) || (m == SW);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a word and sign/zero extends it.
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [3:0]  mode,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{off, 3'b000} +: 8];
  assign h = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = '0;
    case (mode)
      LB:      data = {{24{b[7]}}, b};
      LBU:     data = {24'd0, b};
      LH:      data = {{16{h[15]}}, h};
      LHU:     data = {16'd0, h};
      LW:      data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_pipe.sv
// Byte-addressed data memory with valid/ready request and response
// channels, one request outstanding, fixed read latency.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ADDR_REAL_WIDTH = 20,
  parameter int RD_LATENCY      = 1,
  parameter     INIT_FILE       = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            AddrMode,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  fault
);

  localparam int         DEPTH  = 2 ** ADDR_REAL_WIDTH;
  localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

  if (DATA_WIDTH != 32 || RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_param
    $error("dmem_pipe: DATA_WIDTH must be 32, RD_LATENCY 1..4");
  end

  logic [7:0] mem [DEPTH];

  state_t                     state;
  logic [2:0]                 cnt;
  logic                       armed;
  logic [31:0]                rd_q;
  logic                       fault_q;
  logic                       accept;
  logic                       bad;
  logic                       st;
  logic [ADDR_REAL_WIDTH-3:0] wa;
  logic [1:0]                 off;
  logic [31:0]                word;
  logic [31:0]                ext;
  logic [31:0]                wdat;
  logic [3:0]                 be;

  assign req_ready = armed &&
                     (state == ST_IDLE ||
                      (state == ST_RESP && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == ST_RESP);
  assign RD        = rd_q;
  assign fault     = fault_q;

  assign wa   = A[ADDR_REAL_WIDTH-1:2];
  assign off  = A[1:0];
  assign st   = is_store(AddrMode);
  assign word = {mem[{wa, 2'd3}], mem[{wa, 2'd2}],
                 mem[{wa, 2'd1}], mem[{wa, 2'd0}]};

  load_extend u_ext (
    .word (word),
    .off  (off),
    .mode (AddrMode),
    .data (ext)
  );

  always_comb begin
    bad = (A >> ADDR_REAL_WIDTH) != '0;
    case (AddrMode)
      LB, LBU, SB: ;
      LH, LHU, SH: bad = bad | off[0];
      LW, SW:      bad = bad | (off != 2'd0);
      default:     bad = 1'b1;
    endcase
  end

  always_comb begin
    wdat = WD;
    be   = 4'b0000;
    case (AddrMode)
      SB: begin
        wdat = {4{WD[7:0]}};
        be   = 4'b0001 << off;
      end
      SH: begin
        wdat = {2{WD[15:0]}};
        be   = off[1] ? 4'b1100 : 4'b0011;
      end
      SW:      be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && st && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[{wa, 2'(i)}] <= wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      armed   <= 1'b0;
      rd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        rd_q    <= (st || bad) ? '0 : ext;
        fault_q <= bad;
        cnt     <= LAT_M1;
        state   <= (RD_LATENCY == 1) ? ST_RESP : ST_BUSY;
      end else begin
        unique case (state)
          ST_BUSY: begin
            if (cnt == 3'd1) begin
              state <= ST_RESP;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
          ST_RESP: if (rsp_ready) state <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe at RD_LATENCY=3: vector table plus
// stall, back-to-back and reset sequences.
module tb_dmem_pipe;

  localparam int LAT = 3;

  localparam logic [3:0] M_LB  = 4'd0;
  localparam logic [3:0] M_LH  = 4'd1;
  localparam logic [3:0] M_LW  = 4'd2;
  localparam logic [3:0] M_LBU = 4'd3;
  localparam logic [3:0] M_LHU = 4'd4;
  localparam logic [3:0] M_SB  = 4'd5;
  localparam logic [3:0] M_SH  = 4'd6;
  localparam logic [3:0] M_SW  = 4'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  AddrMode;
  logic [31:0] A;
  logic [31:0] WD;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] RD;
  logic        fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_pipe #(
    .DATA_WIDTH      (32),
    .ADDR_WIDTH      (32),
    .ADDR_REAL_WIDTH (20),
    .RD_LATENCY      (LAT),
    .INIT_FILE       ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .AddrMode  (AddrMode),
    .A         (A),
    .WD        (WD),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .RD        (RD),
    .fault     (fault)
  );

  typedef struct {
    logic [3:0]  m;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        f;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Called at #1 after a rising edge; returns the response fields.
  task automatic xact(input logic [3:0] m, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic f, output int lat);
    int n = 0;
    req_valid = 1'b1;
    AddrMode  = m;
    A         = a;
    WD        = wd;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    AddrMode  = 4'hF;
    A         = '1;
    WD        = '1;
    wait_rsp(lat);
    rd = RD;
    f  = fault;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  vec_t        v[23];
  logic [31:0] rd;
  logic        f;
  int          lat;

  initial begin
    v[0]  = '{M_SW,  32'h100,      32'hDEADBEEF, 32'h0,        1'b0};
    v[1]  = '{M_LW,  32'h100,      32'h0,        32'hDEADBEEF, 1'b0};
    v[2]  = '{M_LB,  32'h103,      32'h0,        32'hFFFFFFDE, 1'b0};
    v[3]  = '{M_LBU, 32'h103,      32'h0,        32'h000000DE, 1'b0};
    v[4]  = '{M_LH,  32'h102,      32'h0,        32'hFFFFDEAD, 1'b0};
    v[5]  = '{M_LHU, 32'h100,      32'h0,        32'h0000BEEF, 1'b0};
    v[6]  = '{M_SH,  32'h101,      32'h1234,     32'h0,        1'b1};
    v[7]  = '{M_LW,  32'h100,      32'h0,        32'hDEADBEEF, 1'b0};
    v[8]  = '{M_LW,  32'h00100000, 32'h0,        32'h0,        1'b1};
    v[9]  = '{4'd9,  32'h100,      32'h0,        32'h0,        1'b1};
    v[10] = '{M_SW,  32'h104,      32'h11223344, 32'h0,        1'b0};
    v[11] = '{M_SB,  32'h105,      32'hFFFFFFA5, 32'h0,        1'b0};
    v[12] = '{M_LB,  32'h105,      32'h0,        32'hFFFFFFA5, 1'b0};
    v[13] = '{M_SH,  32'h106,      32'hFFFF7F01, 32'h0,        1'b0};
    v[14] = '{M_LW,  32'h104,      32'h0,        32'h7F01A544, 1'b0};
    v[15] = '{M_LHU, 32'h106,      32'h0,        32'h00007F01, 1'b0};
    v[16] = '{M_LH,  32'h104,      32'h0,        32'hFFFFA544, 1'b0};
    v[17] = '{M_LBU, 32'h104,      32'h0,        32'h00000044, 1'b0};
    v[18] = '{M_LW,  32'h102,      32'h0,        32'h0,        1'b1};
    v[19] = '{M_LHU, 32'h103,      32'h0,        32'h0,        1'b1};
    v[20] = '{M_SB,  32'h000FFFFF, 32'h00000080, 32'h0,        1'b0};
    v[21] = '{M_LB,  32'h000FFFFF, 32'h0,        32'hFFFFFF80, 1'b0};
    v[22] = '{M_SW,  32'h00100004, 32'h55555555, 32'h0,        1'b1};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    AddrMode  = 4'd0;
    A         = '0;
    WD        = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_fault",     {31'd0, fault},     32'd0);
    chk("rst_rd",        RD,                 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_first_cycle", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_first", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 23; i++) begin
      xact(v[i].m, v[i].a, v[i].wd, rd, f, lat);
      chk($sformatf("vec%0d_rd", i), rd, v[i].rd);
      chk($sformatf("vec%0d_fault", i), {31'd0, f}, {31'd0, v[i].f});
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
    end

    // Response held while the consumer stalls, then back-to-back accept.
    req_valid = 1'b1;
    AddrMode  = M_LW;
    A         = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    chk("stall_lat", 32'(lat), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rd", RD, 32'hDEADBEEF);
    end
    req_valid = 1'b1;
    AddrMode  = M_LBU;
    A         = 32'h103;
    rsp_ready = 1'b1;
    #1;
    chk("b2b_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("b2b_busy", {31'd0, rsp_valid}, 32'd0);
    wait_rsp(lat);
    chk("b2b_lat", 32'(lat), 32'(LAT));
    chk("b2b_rd", RD, 32'h000000DE);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset while BUSY after a committed store.
    req_valid = 1'b1;
    AddrMode  = M_SW;
    A         = 32'h200;
    WD        = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("busy_rst_valid", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("busy_rst_hold", {31'd0, rsp_valid}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("busy_rst_ready0", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    xact(M_LW, 32'h200, 32'h0, rd, f, lat);
    chk("after_rst_rd", rd, 32'hCAFEF00D);
    chk("after_rst_fault", {31'd0, f}, 32'd0);

    // Reset while a response is presented drops it.
    req_valid = 1'b1;
    AddrMode  = M_LW;
    A         = 32'h200;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    chk("resp_rst_pre", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("resp_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("resp_rst_rd", RD, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
